tlul_a_arbiter: RTL and testbench

TLUL_A_ARBITER -- requirements
Module: tlul_a_arbiter

---
 rtl/tlul_pkg.sv | 54 +++++
 rtl/tlul_rr_picker.sv | 31 +++
 rtl/tlul_a_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_tlul_a_arbiter.sv | 571 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the A-channel arbiter: widths, opcodes,
// payload layouts, arbiter state encoding and the 3-way modulo increment.
package tlul_pkg;

  localparam int unsigned N_MASTERS  = 3;
  localparam int unsigned TL_AW      = 32;
  localparam int unsigned TL_DW      = 32;
  localparam int unsigned TL_MW      = 4;
  localparam int unsigned TL_A_PAY_W = 77;
  localparam int unsigned TL_D_PAY_W = 43;
  localparam int unsigned CNT_W      = 4;   // holds 0..15 outstanding
  localparam int unsigned STAT_W     = 16;

  // A and D opcodes share encodings, so they live in separate enums.
  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    tl_a_op_e           opcode;
    logic [2:0]         param;
    logic [2:0]         size;
    logic [TL_AW-1:0]   address;
    logic [TL_MW-1:0]   mask;
    logic [TL_DW-1:0]   data;
  } tl_a_pay_t;

  typedef struct packed {
    tl_d_op_e           opcode;
    logic [2:0]         param;
    logic [2:0]         size;
    logic               sink;
    logic [TL_DW-1:0]   data;
    logic               error;
  } tl_d_pay_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  // Next master index modulo 3; an out-of-range index folds back to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/tlul_rr_picker.sv
// 3-way round-robin picker: first eligible master starting at rr_ptr,
// wrapping modulo 3. Purely combinational.
module tlul_rr_picker
  import tlul_pkg::*;
(
  input  logic [1:0] rr_ptr,
  input  logic [2:0] eligible,
  output logic       any_elig,
  output logic [1:0] winner
);

  logic [3:0] elig_ext;

  assign elig_ext = {1'b0, eligible};

  // Probe rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); the first eligible one wins.
  always_comb begin
    logic [1:0] cand;
    any_elig = 1'b0;
    winner   = 2'd0;
    cand     = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!any_elig && elig_ext[cand]) begin
        any_elig = 1'b1;
        winner   = cand;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/tlul_a_arbiter.sv
// Three-master TL-UL A-channel arbiter with combinational D-channel return
// routing and per-master outstanding-request limiting.
// Optional: define TLUL_ARB_STATS_EN to add the grant_cnt output with one
// wrapping 16-bit grant counter per master.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request held; pick an eligible master, accept it
// ST_SEND | captured request presented on s_a until s_a_ready
module tlul_a_arbiter
  import tlul_pkg::*;
#(
  parameter int SRC_WIDTH = 2,
  parameter int MAX_OUT   = 4,
  parameter int A_PAY_W   = 77,
  parameter int D_PAY_W   = 43
) (
  input  logic                     clk_100,
  input  logic                     reset,
  input  logic [2:0]               m_a_valid,
  output logic [2:0]               m_a_ready,
  input  logic [3*SRC_WIDTH-1:0]   m_a_source,
  input  logic [3*A_PAY_W-1:0]     m_a_payload,
  output logic                     s_a_valid,
  input  logic                     s_a_ready,
  output logic [SRC_WIDTH+1:0]     s_a_source,
  output logic [A_PAY_W-1:0]       s_a_payload,
  input  logic                     s_d_valid,
  output logic                     s_d_ready,
  input  logic [SRC_WIDTH+1:0]     s_d_source,
  input  logic [D_PAY_W-1:0]       s_d_payload,
  output logic [2:0]               m_d_valid,
  input  logic [2:0]               m_d_ready,
  output logic [3*SRC_WIDTH-1:0]   m_d_source,
  output logic [3*D_PAY_W-1:0]     m_d_payload,
  output logic                     route_err
`ifdef TLUL_ARB_STATS_EN
  ,
  output logic [3*STAT_W-1:0]      grant_cnt
`endif
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  arb_state_e           state_q, state_d;
  logic [1:0]           rr_ptr_q;
  logic [1:0]           win_q;
  logic [SRC_WIDTH-1:0] src_q;
  logic [A_PAY_W-1:0]   pay_q;
  logic [CNT_W-1:0]     out_cnt_q [N_MASTERS];

  logic [2:0]           eligible;
  logic                 any_elig;
  logic [1:0]           pick;
  logic                 grant;
  logic                 a_hs;
  logic [SRC_WIDTH-1:0] src_sel;
  logic [A_PAY_W-1:0]   pay_sel;

  logic [1:0]           d_idx;
  logic                 d_legal;
  logic                 d_hs;
  logic [2:0]           inc_vec;
  logic [2:0]           dec_vec;
  logic                 underflow;
  logic                 route_err_d;

  // A master may compete only while it is below its outstanding cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 3; i++) begin
      eligible[i] = m_a_valid[i] && (out_cnt_q[i] < MAX_OUT_C);
    end
  end

  tlul_rr_picker u_picker (
    .rr_ptr   (rr_ptr_q),
    .eligible (eligible),
    .any_elig (any_elig),
    .winner   (pick)
  );

  // Select the winner's source and payload for capture.
  always_comb begin
    src_sel = '0;
    pay_sel = '0;
    for (int i = 0; i < 3; i++) begin
      if (pick == 2'(i)) begin
        src_sel = m_a_source[i*SRC_WIDTH +: SRC_WIDTH];
        pay_sel = m_a_payload[i*A_PAY_W +: A_PAY_W];
      end
    end
  end

  // Next state and A-channel handshake outputs; ready is masked in reset.
  always_comb begin
    state_d   = state_q;
    m_a_ready = '0;
    s_a_valid = 1'b0;
    grant     = 1'b0;
    a_hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig && !reset) begin
          grant     = 1'b1;
          m_a_ready = 3'b001 << pick;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        s_a_valid = 1'b1;
        if (s_a_ready) begin
          a_hs    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_a_source  = {win_q, src_q};
  assign s_a_payload = pay_q;

  // State, hold register and round-robin pointer.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd0;
      win_q    <= 2'd0;
      src_q    <= '0;
      pay_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q <= pick;
        src_q <= src_sel;
        pay_q <= pay_sel;
      end
      if (a_hs) begin
        rr_ptr_q <= rr_next(win_q);
      end
    end
  end

  assign d_idx   = s_d_source[SRC_WIDTH+1:SRC_WIDTH];
  assign d_legal = (d_idx != 2'd3);

  // Route the D beat to its master; index 3 is sunk so the slave never stalls.
  always_comb begin
    m_d_valid = '0;
    s_d_ready = 1'b1;
    if (d_legal) begin
      for (int i = 0; i < 3; i++) begin
        if (d_idx == 2'(i)) begin
          m_d_valid[i] = s_d_valid;
          s_d_ready    = m_d_ready[i];
        end
      end
    end
  end

  assign d_hs        = s_d_valid && s_d_ready;
  assign m_d_source  = {3{s_d_source[SRC_WIDTH-1:0]}};
  assign m_d_payload = {3{s_d_payload}};

  // Counter events for this cycle and the error condition they imply.
  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    underflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inc_vec[i] = a_hs && (win_q == 2'(i));
      dec_vec[i] = d_hs && d_legal && (d_idx == 2'(i));
      if (dec_vec[i] && !inc_vec[i] && (out_cnt_q[i] == '0)) begin
        underflow = 1'b1;
      end
    end
    route_err_d = underflow || (d_hs && !d_legal);
  end

  // Outstanding counters (simultaneous inc/dec cancel) and error pulse.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        out_cnt_q[i] <= '0;
      end
      route_err <= 1'b0;
    end else begin
      route_err <= route_err_d;
      for (int i = 0; i < 3; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          out_cnt_q[i] <= out_cnt_q[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i] && (out_cnt_q[i] != '0)) begin
          out_cnt_q[i] <= out_cnt_q[i] - 1'b1;
        end
      end
    end
  end

`ifdef TLUL_ARB_STATS_EN
  // Per-master grant statistics, wrapping naturally at 16 bits.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (inc_vec[i]) begin
          grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlul_a_arbiter.sv
// Self-checking bench for tlul_a_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_tlul_a_arbiter;
  import tlul_pkg::*;

  localparam int SW = 2;
  localparam int AW = 77;
  localparam int DW = 43;
  localparam int MAXO = 4;

  logic              clk_100 = 1'b0;
  logic              reset;
  logic [2:0]        m_a_valid;
  logic [2:0]        m_a_ready;
  logic [3*SW-1:0]   m_a_source;
  logic [3*AW-1:0]   m_a_payload;
  logic              s_a_valid;
  logic              s_a_ready;
  logic [SW+1:0]     s_a_source;
  logic [AW-1:0]     s_a_payload;
  logic              s_d_valid;
  logic              s_d_ready;
  logic [SW+1:0]     s_d_source;
  logic [DW-1:0]     s_d_payload;
  logic [2:0]        m_d_valid;
  logic [2:0]        m_d_ready;
  logic [3*SW-1:0]   m_d_source;
  logic [3*DW-1:0]   m_d_payload;
  logic              route_err;
`ifdef TLUL_ARB_STATS_EN
  logic [47:0]       grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_100 = ~clk_100;

  tlul_a_arbiter #(
    .SRC_WIDTH (SW),
    .MAX_OUT   (MAXO),
    .A_PAY_W   (AW),
    .D_PAY_W   (DW)
  ) dut (
    .clk_100     (clk_100),
    .reset       (reset),
    .m_a_valid   (m_a_valid),
    .m_a_ready   (m_a_ready),
    .m_a_source  (m_a_source),
    .m_a_payload (m_a_payload),
    .s_a_valid   (s_a_valid),
    .s_a_ready   (s_a_ready),
    .s_a_source  (s_a_source),
    .s_a_payload (s_a_payload),
    .s_d_valid   (s_d_valid),
    .s_d_ready   (s_d_ready),
    .s_d_source  (s_d_source),
    .s_d_payload (s_d_payload),
    .m_d_valid   (m_d_valid),
    .m_d_ready   (m_d_ready),
    .m_d_source  (m_d_source),
    .m_d_payload (m_d_payload),
    .route_err   (route_err)
`ifdef TLUL_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  function automatic logic [AW-1:0] mk_a(tl_a_op_e op, logic [31:0] addr, logic [31:0] data);
    tl_a_pay_t p;
    p.opcode  = op;
    p.param   = 3'd0;
    p.size    = 3'd2;
    p.address = addr;
    p.mask    = 4'hF;
    p.data    = data;
    return p;
  endfunction

  task automatic idle_inputs();
    m_a_valid   = '0;
    m_a_source  = '0;
    m_a_payload = '0;
    s_a_ready   = 1'b0;
    s_d_valid   = 1'b0;
    s_d_source  = '0;
    s_d_payload = '0;
    m_d_ready   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk_100);
    @(negedge clk_100);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    m_a_valid  = 3'b111;
    s_a_ready  = 1'b1;
    s_d_valid  = 1'b1;
    s_d_source = 4'b1100;
    @(negedge clk_100);
    @(negedge clk_100);
    #1;
    n_checks++;
    if (m_a_ready !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_m_a_ready: got %b expected 000", m_a_ready);
    end
    n_checks++;
    if (s_a_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_s_a_valid: got %b expected 0", s_a_valid);
    end
    n_checks++;
    if (route_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_route_err: got %b expected 0", route_err);
    end
    idle_inputs();
  endtask

  task automatic test_single_get();
    tl_a_pay_t pv;
    do_reset();
    m_a_valid          = 3'b001;
    m_a_source[1:0]    = 2'd0;
    m_a_payload[AW-1:0] = mk_a(A_GET, 32'h0000_1000, 32'h0);
    s_a_ready          = 1'b1;
    #1;
    n_checks++;
    if (m_a_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL get_accept: got %b expected 001", m_a_ready);
    end
    n_checks++;
    if (s_a_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL get_no_early_valid: got %b expected 0", s_a_valid);
    end
    @(negedge clk_100);
    m_a_valid = 3'b000;
    #1;
    pv = tl_a_pay_t'(s_a_payload);
    n_checks++;
    if (s_a_valid !== 1'b1 || s_a_source !== 4'b0000) begin
      n_errors++;
      $display("FAIL get_forward: got valid=%b src=%b expected valid=1 src=0000", s_a_valid, s_a_source);
    end
    n_checks++;
    if (pv.address !== 32'h0000_1000 || pv.opcode !== A_GET) begin
      n_errors++;
      $display("FAIL get_payload: got addr=%h op=%0d expected addr=00001000 op=4", pv.address, pv.opcode);
    end
    @(negedge clk_100);
    #1;
    n_checks++;
    if (s_a_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL get_valid_drop: got %b expected 0", s_a_valid);
    end
    s_d_valid  = 1'b1;
    s_d_source = 4'b0000;
    m_d_ready  = 3'b001;
    #1;
    n_checks++;
    if (m_d_valid !== 3'b001 || s_d_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL get_resp_route: got mdv=%b sdr=%b expected mdv=001 sdr=1", m_d_valid, s_d_ready);
    end
    @(negedge clk_100);
    s_d_valid = 1'b0;
    #1;
    n_checks++;
    if (route_err !== 1'b0) begin
      n_errors++;
      $display("FAIL get_resp_no_err: got %b expected 0", route_err);
    end
  endtask

  task automatic test_rr_order();
    int order[4] = '{0, 1, 2, 0};
    logic [2:0] exp;
    do_reset();
    m_a_valid   = 3'b111;
    m_a_source  = 6'b10_01_11;
    m_a_payload = {mk_a(A_GET, 32'h2, 32'h0), mk_a(A_GET, 32'h1, 32'h0), mk_a(A_GET, 32'h0, 32'h0)};
    s_a_ready   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk_100);
      #1;
      exp = (k % 2 == 0) ? (3'b001 << order[k/2]) : 3'b000;
      n_checks++;
      if (m_a_ready !== exp) begin
        n_errors++;
        $display("FAIL rr_grant cycle %0d: got %b expected %b", k, m_a_ready, exp);
      end
      if (k % 2 == 1) begin
        n_checks++;
        if (s_a_source[3:2] !== 2'(order[k/2])) begin
          n_errors++;
          $display("FAIL rr_source cycle %0d: got %0d expected %0d", k, s_a_source[3:2], order[k/2]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_d_route();
    tl_a_pay_t pv;
    logic [DW-1:0] dpay;
    do_reset();
    m_a_valid            = 3'b010;
    m_a_source[3:2]      = 2'd2;
    m_a_payload[2*AW-1:AW] = mk_a(A_PUT_FULL_DATA, 32'h0000_2000, 32'hCAFE_BABE);
    s_a_ready            = 1'b1;
    #1;
    n_checks++;
    if (m_a_ready !== 3'b010) begin
      n_errors++;
      $display("FAIL put_accept: got %b expected 010", m_a_ready);
    end
    @(negedge clk_100);
    m_a_valid = 3'b000;
    #1;
    pv = tl_a_pay_t'(s_a_payload);
    n_checks++;
    if (s_a_source !== 4'b0110 || pv.data !== 32'hCAFE_BABE || pv.opcode !== A_PUT_FULL_DATA) begin
      n_errors++;
      $display("FAIL put_forward: got src=%b data=%h op=%0d expected src=0110 data=cafebabe op=0",
               s_a_source, pv.data, pv.opcode);
    end
    @(negedge clk_100);
    dpay        = {D_ACCESS_ACK, 3'd0, 3'd2, 1'b0, 32'h0, 1'b0};
    s_a_ready   = 1'b0;
    s_d_valid   = 1'b1;
    s_d_source  = 4'b0110;
    s_d_payload = dpay;
    m_d_ready   = 3'b010;
    #1;
    n_checks++;
    if (m_d_valid !== 3'b010 || s_d_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL put_resp_route: got mdv=%b sdr=%b expected mdv=010 sdr=1", m_d_valid, s_d_ready);
    end
    n_checks++;
    if (m_d_source[3:2] !== 2'd2 || m_d_payload[2*DW-1:DW] !== dpay) begin
      n_errors++;
      $display("FAIL put_resp_fields: got src=%0d pay=%h expected src=2 pay=%h",
               m_d_source[3:2], m_d_payload[2*DW-1:DW], dpay);
    end
    @(negedge clk_100);
    s_d_valid = 1'b0;
    #1;
    n_checks++;
    if (route_err !== 1'b0) begin
      n_errors++;
      $display("FAIL put_resp_no_err: got %b expected 0", route_err);
    end
    s_d_valid = 1'b1;
    @(negedge clk_100);
    s_d_valid = 1'b0;
    #1;
    n_checks++;
    if (route_err !== 1'b1) begin
      n_errors++;
      $display("FAIL put_underflow_err: got %b expected 1", route_err);
    end
    @(negedge clk_100);
    #1;
    n_checks++;
    if (route_err !== 1'b0) begin
      n_errors++;
      $display("FAIL put_underflow_pulse: got %b expected 0", route_err);
    end
    idle_inputs();
  endtask

  task automatic test_max_out();
    logic [2:0] exp;
    do_reset();
    m_a_valid  = 3'b100;
    m_a_source = 6'b01_00_10;
    s_a_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk_100);
      #1;
      exp = (k % 2 == 0) ? 3'b100 : 3'b000;
      n_checks++;
      if (m_a_ready !== exp) begin
        n_errors++;
        $display("FAIL max_out_fill cycle %0d: got %b expected %b", k, m_a_ready, exp);
      end
    end
    @(negedge clk_100);
    #1;
    n_checks++;
    if (m_a_ready !== 3'b000) begin
      n_errors++;
      $display("FAIL max_out_capped: got %b expected 000", m_a_ready);
    end
    m_a_valid = 3'b101;
    #1;
    n_checks++;
    if (m_a_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL max_out_other_granted: got %b expected 001", m_a_ready);
    end
    @(negedge clk_100);
    @(negedge clk_100);
    #1;
    n_checks++;
    if (m_a_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL max_out_skip_capped: got %b expected 001", m_a_ready);
    end
    @(negedge clk_100);
    s_d_valid  = 1'b1;
    s_d_source = 4'b1000;
    m_d_ready  = 3'b100;
    #1;
    n_checks++;
    if (m_d_valid !== 3'b100) begin
      n_errors++;
      $display("FAIL max_out_resp_route: got %b expected 100", m_d_valid);
    end
    @(negedge clk_100);
    s_d_valid = 1'b0;
    #1;
    n_checks++;
    if (m_a_ready !== 3'b100) begin
      n_errors++;
      $display("FAIL max_out_released: got %b expected 100", m_a_ready);
    end
    idle_inputs();
  endtask

  task automatic test_illegal_route();
    do_reset();
    s_d_valid  = 1'b1;
    s_d_source = 4'b1100;
    m_d_ready  = 3'b000;
    #1;
    n_checks++;
    if (s_d_ready !== 1'b1 || m_d_valid !== 3'b000) begin
      n_errors++;
      $display("FAIL illegal_sink: got sdr=%b mdv=%b expected sdr=1 mdv=000", s_d_ready, m_d_valid);
    end
    @(negedge clk_100);
    s_d_valid = 1'b0;
    #1;
    n_checks++;
    if (route_err !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_err: got %b expected 1", route_err);
    end
    @(negedge clk_100);
    #1;
    n_checks++;
    if (route_err !== 1'b0) begin
      n_errors++;
      $display("FAIL illegal_err_pulse: got %b expected 0", route_err);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_send();
    do_reset();
    m_a_valid  = 3'b001;
    m_a_source = 6'b00_01_00;
    s_a_ready  = 1'b1;
    #1;
    n_checks++;
    if (m_a_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL rsend_first_grant: got %b expected 001", m_a_ready);
    end
    @(negedge clk_100);
    m_a_valid = 3'b010;
    @(negedge clk_100);
    s_a_ready = 1'b0;
    @(negedge clk_100);
    #1;
    n_checks++;
    if (s_a_valid !== 1'b1 || s_a_source[3:2] !== 2'd1) begin
      n_errors++;
      $display("FAIL rsend_holding: got valid=%b idx=%0d expected valid=1 idx=1", s_a_valid, s_a_source[3:2]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (s_a_valid !== 1'b0 || m_a_ready !== 3'b000) begin
      n_errors++;
      $display("FAIL rsend_async_clear: got valid=%b ready=%b expected valid=0 ready=000", s_a_valid, m_a_ready);
    end
    @(negedge clk_100);
    reset      = 1'b0;
    m_a_valid  = 3'b000;
    s_d_valid  = 1'b1;
    s_d_source = 4'b0000;
    m_d_ready  = 3'b001;
    #1;
    n_checks++;
    if (s_a_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rsend_no_stale: got %b expected 0", s_a_valid);
    end
    @(negedge clk_100);
    s_d_valid = 1'b0;
    #1;
    n_checks++;
    if (route_err !== 1'b1) begin
      n_errors++;
      $display("FAIL rsend_cnt_cleared: got %b expected 1", route_err);
    end
    m_a_valid = 3'b111;
    s_a_ready = 1'b1;
    #1;
    n_checks++;
    if (m_a_ready !== 3'b001) begin
      n_errors++;
      $display("FAIL rsend_restart_m0: got %b expected 001", m_a_ready);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit            busy;
    int            w, ptr, exp_w, idx, inc, dec, delta;
    logic [SW-1:0] src;
    logic [AW-1:0] pay;
    int            cnt[3];
    int            grants[3];
    bit            err_pend, new_err;
    logic [2:0]    exp_ready, exp_mdv;
    logic          exp_sdr;
    int            r;
    do_reset();
    busy = 0; w = 0; ptr = 0; src = '0; pay = '0; err_pend = 0;
    for (int j = 0; j < 3; j++) begin
      cnt[j] = 0;
      grants[j] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      m_a_valid  = 3'($urandom_range(0, 7));
      m_a_source = 6'($urandom);
      for (int b = 0; b < 3*AW; b++) m_a_payload[b] = 1'($urandom_range(0, 1));
      s_a_ready  = ($urandom_range(0, 3) != 0);
      s_d_valid  = ($urandom_range(0, 2) == 0);
      r          = $urandom_range(0, 9);
      idx        = (r == 9) ? 3 : (r % 3);
      s_d_source = {2'(idx), 2'($urandom)};
      for (int b = 0; b < DW; b++) s_d_payload[b] = 1'($urandom_range(0, 1));
      m_d_ready  = 3'($urandom_range(0, 7));
      #1;

      exp_w = -1;
      if (!busy) begin
        for (int k = 0; k < 3; k++) begin
          if (exp_w < 0 && m_a_valid[(ptr + k) % 3] && cnt[(ptr + k) % 3] < MAXO) exp_w = (ptr + k) % 3;
        end
      end
      exp_ready = (exp_w >= 0) ? (3'b001 << exp_w) : 3'b000;
      exp_mdv   = (idx < 3) ? (3'(s_d_valid) << idx) : 3'b000;
      exp_sdr   = (idx == 3) ? 1'b1 : m_d_ready[idx];

      n_checks++;
      if (m_a_ready !== exp_ready) begin
        n_errors++;
        $display("FAIL rand_m_a_ready cycle %0d: got %b expected %b", cyc, m_a_ready, exp_ready);
      end
      n_checks++;
      if (s_a_valid !== busy) begin
        n_errors++;
        $display("FAIL rand_s_a_valid cycle %0d: got %b expected %b", cyc, s_a_valid, busy);
      end
      if (busy) begin
        n_checks++;
        if (s_a_source !== {2'(w), src} || s_a_payload !== pay) begin
          n_errors++;
          $display("FAIL rand_s_a_fields cycle %0d: got src=%b pay=%h expected src=%b pay=%h",
                   cyc, s_a_source, s_a_payload, {2'(w), src}, pay);
        end
      end
      n_checks++;
      if (m_d_valid !== exp_mdv || s_d_ready !== exp_sdr) begin
        n_errors++;
        $display("FAIL rand_d_route cycle %0d: got mdv=%b sdr=%b expected mdv=%b sdr=%b",
                 cyc, m_d_valid, s_d_ready, exp_mdv, exp_sdr);
      end
      if (idx < 3 && s_d_valid) begin
        n_checks++;
        if (m_d_source[idx*SW +: SW] !== s_d_source[SW-1:0] || m_d_payload[idx*DW +: DW] !== s_d_payload) begin
          n_errors++;
          $display("FAIL rand_d_fields cycle %0d: got src=%b expected %b", cyc,
                   m_d_source[idx*SW +: SW], s_d_source[SW-1:0]);
        end
      end
      n_checks++;
      if (route_err !== err_pend) begin
        n_errors++;
        $display("FAIL rand_route_err cycle %0d: got %b expected %b", cyc, route_err, err_pend);
      end

      new_err = 0;
      inc = -1;
      dec = -1;
      if (busy && s_a_ready) inc = w;
      if (s_d_valid && exp_sdr) begin
        if (idx == 3) new_err = 1;
        else dec = idx;
      end
      for (int j = 0; j < 3; j++) begin
        delta = ((inc == j) ? 1 : 0) - ((dec == j) ? 1 : 0);
        if (delta == 1) cnt[j]++;
        else if (delta == -1) begin
          if (cnt[j] == 0) new_err = 1;
          else cnt[j]--;
        end
      end
      if (inc >= 0) begin
        grants[inc]++;
        ptr  = (inc + 1) % 3;
        busy = 0;
      end else if (exp_w >= 0) begin
        busy = 1;
        w    = exp_w;
        src  = m_a_source[exp_w*SW +: SW];
        pay  = m_a_payload[exp_w*AW +: AW];
      end
      err_pend = new_err;
      @(negedge clk_100);
    end
`ifdef TLUL_ARB_STATS_EN
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (grant_cnt[j*16 +: 16] !== 16'(grants[j])) begin
        n_errors++;
        $display("FAIL rand_grant_cnt[%0d]: got %0d expected %0d", j, grant_cnt[j*16 +: 16], grants[j]);
      end
    end
`endif
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_get();
    test_rr_order();
    test_d_route();
    test_max_out();
    test_illegal_route();
    test_reset_in_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
